spi_controller: RTL
===================

SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCLK half-period (legal 2..255).
REQ-002 SHALL have parameter GAP_CYCLES, default 2, meaning minimum nCS-high clk cycles between frames (legal 1..255).
REQ-003 SHALL have port clk  input  1  system clock; the block uses one clock and all state is clocked on the rising edge of clk.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  controller can accept a request.
REQ-007 SHALL have port req_rw  input  1  frame bit 15 (1 = write).
REQ-008 SHALL have port req_addr  input  7  register address, frame bits 14:8.
REQ-009 SHALL have port req_data  input  8  payload, frame bits 7:0.
REQ-010 SHALL have port SCLK  output  1  serial clock, mode 0 (idle low).
REQ-011 SHALL have port COPI  output  1  serial data out, MSB first.
REQ-012 SHALL have port nCS  output  1  chip select, active low.
REQ-013 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a frame completes.

Function
REQ-015 SHALL implement states IDLE, SETUP, SHIFT, GAP; req_ready SHALL be 1 only in IDLE.
REQ-016 SHALL accept a request on the cycle req_valid && req_ready, latch {req_rw, req_addr, req_data} into a 16-bit shift register, and go to SETUP.
REQ-017 SHALL ignore request inputs while not in IDLE; changes after acceptance SHALL NOT affect the frame in flight.
REQ-018 In SETUP, SHALL drive nCS=0, SCLK=0, COPI=frame[15] from the first cycle after acceptance, for CLK_DIV cycles, then enter SHIFT.
REQ-019 In SHIFT, SHALL toggle SCLK every CLK_DIV cycles, producing exactly 16 rising edges.
REQ-020 SHALL change COPI only on SCLK falling edges, presenting the next lower bit; COPI SHALL be stable for CLK_DIV cycles before and after every rising edge.
REQ-021 After the 16th falling edge, SHALL hold SCLK=0 and nCS=0 for CLK_DIV cycles, then drive nCS=1 and pulse done for that same single cycle, entering GAP.
REQ-022 nCS SHALL therefore be low for exactly 33*CLK_DIV cycles per frame (132 at default).
REQ-023 In GAP, SHALL hold nCS=1, SCLK=0, COPI=0 for GAP_CYCLES cycles, then return to IDLE.
REQ-024 Back-to-back requests (req_valid held high) SHALL be accepted on the first IDLE cycle after GAP, with no extra bubble.
REQ-025 The half-period counter SHALL be ceil(log2(CLK_DIV+1)) bits and the bit counter 5 bits; neither SHALL wrap within a frame.
REQ-026 SCLK SHALL never glitch: it SHALL be a registered output, low in IDLE, SETUP and GAP.

Reset
REQ-027 While rst_n=0 at a clk edge, SHALL set state=IDLE, nCS=1, SCLK=0, COPI=0, done=0, busy=0, and clear the shift register and counters.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no done pulse; nCS SHALL be high from the next edge.
REQ-029 req_ready SHALL be 1 on the first cycle after rst_n returns high.

Structure
REQ-030 Shared package spi_pkg SHALL hold FRAME_W=16, ADDR_W=7, DATA_W=8, the state enum, and the register address constants 0x00..0x04 (output enables 7:0, 15:8, PWM enables 7:0, 15:8, duty cycle).
REQ-031 SHALL contain one sub-module, spi_clk_gen, that produces one-cycle rise/fall strobes from CLK_DIV; the FSM and shift register SHALL remain in spi_controller.

Verification
REQ-032 Single write {1, 0x04, 0x80}, CLK_DIV=4 -> COPI sampled on the 16 SCLK rises = 0x8480; nCS low 132 cycles; one done pulse.
REQ-033 Loopback into the existing SPI peripheral: writes 0x00<-0xFF, 0x02<-0x01, 0x04<-0x40 -> peripheral registers equal the written values; PWM output 0 has 25% duty.
REQ-034 Back-to-back: req_valid held high for 3 requests -> 3 frames, nCS high exactly GAP_CYCLES between them, req_ready high one cycle per accept.
REQ-035 Request inputs changed during a frame -> frame contents unchanged, no second accept until IDLE.
REQ-036 rst_n pulsed low at SCLK rise 7 -> nCS=1, SCLK=0, COPI=0 next edge, no done, next request frames correctly.
REQ-037 CLK_DIV=2, GAP_CYCLES=1 -> nCS low 66 cycles, SCLK period 4 cycles, frame bits correct.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-write controller.
// Holds the frame geometry, the controller state encoding, the register
// map of the attached peripheral and a frame packing helper.
package spi_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned DATA_W  = 8;

  // Peripheral register map
  localparam logic [ADDR_W-1:0] REG_OUT_EN_LO = 7'h00;  // output enables 7:0
  localparam logic [ADDR_W-1:0] REG_OUT_EN_HI = 7'h01;  // output enables 15:8
  localparam logic [ADDR_W-1:0] REG_PWM_EN_LO = 7'h02;  // PWM enables 7:0
  localparam logic [ADDR_W-1:0] REG_PWM_EN_HI = 7'h03;  // PWM enables 15:8
  localparam logic [ADDR_W-1:0] REG_DUTY      = 7'h04;  // PWM duty cycle

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StGap
  } state_e;

  // Frame layout: bit 15 = write, 14:8 = address, 7:0 = payload
  function automatic logic [FRAME_W-1:0] pack_frame(input logic              rw,
                                                    input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] data);
    return {rw, addr, data};
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK timing strobe generator.
// While en is high, counts CLK_DIV clk cycles per SCLK half-period and
// emits a one-cycle strobe at the end of each half-period: rise at the end
// of a low half, fall at the end of a high half. The first strobe after en
// rises is always rise. Dropping en clears the counter and phase.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   en    : run the half-period counter
//   rise  : one-cycle strobe, SCLK should go high at the next edge
//   fall  : one-cycle strobe, SCLK should go low at the next edge
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = $clog2(CLK_DIV + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;  // 0: low half-period, 1: high half-period
  logic            tick;

  assign tick = en && (cnt_q == CntW'(CLK_DIV - 1));
  assign rise = tick && !phase_q;
  assign fall = tick && phase_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      cnt_d   = '0;
      phase_d = !phase_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write controller: serialises one 16-bit {rw, addr, data}
// frame per accepted request, MSB first, framed by nCS.
//   clk, rst_n          : clock, synchronous active-low reset
//   req_valid/req_ready : request handshake (ready only when idle)
//   req_rw/addr/data    : frame fields, latched on accept
//   SCLK, COPI, nCS     : serial bus, all driven straight from flops
//   busy                : controller not idle
//   done                : one-cycle pulse on the cycle nCS returns high
module spi_controller
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              SCLK,
  output logic              COPI,
  output logic              nCS,
  output logic              busy,
  output logic              done
);

  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned BitW = 5;
  localparam logic [BitW-1:0] AllBits = BitW'(FRAME_W);

  state_e              state_q, state_d;
  logic [FRAME_W-1:0]  shreg_q, shreg_d;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;
  logic                sclk_q, sclk_d;
  logic                ncs_q, ncs_d;
  logic                done_q, done_d;
  logic                clk_en, rise, fall;

  assign clk_en = (state_q == StSetup) || (state_q == StShift);

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (clk_en),
    .rise (rise),
    .fall (fall)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sclk_d    = sclk_q;
    ncs_d     = ncs_q;
    done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          shreg_d   = pack_frame(req_rw, req_addr, req_data);
          bit_cnt_d = '0;
          ncs_d     = 1'b0;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        if (rise) begin
          sclk_d  = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (rise) begin
          // The rise strobe after the last fall ends the trailing hold.
          if (bit_cnt_q == AllBits) begin
            ncs_d     = 1'b1;
            done_d    = 1'b1;
            gap_cnt_d = '0;
            state_d   = StGap;
          end else begin
            sclk_d = 1'b1;
          end
        end else if (fall) begin
          // Zeros shift in, so COPI is already 0 once all bits are out.
          sclk_d    = 1'b0;
          shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BitW'(1);
        end
      end
      StGap: begin
        if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      sclk_q    <= 1'b0;
      ncs_q     <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sclk_q    <= sclk_d;
      ncs_q     <= ncs_d;
      done_q    <= done_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign SCLK      = sclk_q;
  assign COPI      = shreg_q[FRAME_W-1];
  assign nCS       = ncs_q;
  assign done      = done_q;

endmodule
